dff_pipe: RTL and testbench
===========================

DFF_PIPE -- requirements
Module: dff_pipe

Interface
REQ-001 Parameter WIDTH, default 8, data width in bits; SHALL be >= 1.
REQ-002 Parameter STAGES, default 3, pipeline depth in registers; SHALL be >= 1.
REQ-003 Parameter RESET_VAL, default '0, WIDTH-bit value loaded into every data register on reset.
REQ-004 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 flush  input  1  synchronous clear of all stage valids.
REQ-007 d  input  WIDTH  input data.
REQ-008 in_valid  input  1  d is presented for transfer.
REQ-009 in_ready  output  1  pipeline accepts d this cycle.
REQ-010 q  output  WIDTH  data of the last stage.
REQ-011 qb  output  WIDTH  bitwise complement of q.
REQ-012 out_valid  output  1  q holds a valid item.
REQ-013 out_ready  input  1  consumer takes q this cycle.
REQ-014 count  output  CW  number of valid stages, CW = $clog2(STAGES+1).

Function
REQ-015 Stage i SHALL hold data[i] and valid[i]; stage 0 is the input stage, stage STAGES-1 drives q/out_valid.
REQ-016 Stage i "can_take" SHALL be !valid[i] || can_take[i+1]; for the last stage, !valid || out_ready.
REQ-017 in_ready SHALL equal can_take[0] && !flush.
REQ-018 Input transfer occurs when in_valid && in_ready; output transfer occurs when out_valid && out_ready.
REQ-019 On a cycle where stage i can_take, stage i SHALL load data/valid from stage i-1 (or d/in_valid-transfer for stage 0); otherwise it SHALL hold.
REQ-020 Bubbles SHALL collapse: an item SHALL advance into any empty downstream stage even while the output is stalled.
REQ-021 Latency SHALL be exactly STAGES cycles from input transfer to out_valid when no stall occurs; throughput SHALL be one item per cycle.
REQ-022 Full (all valid) with out_ready=1 and in_valid=1 SHALL accept and emit in the same cycle; count unchanged.
REQ-023 Full with out_ready=0 SHALL hold all data and deassert in_ready; no item is lost or duplicated.
REQ-024 Empty: out_valid=0, q SHALL still show data[STAGES-1] (stale value), qb = ~q.
REQ-025 flush=1 SHALL clear all valid bits at the next edge, drop any input on that cycle, leave data registers unchanged; count becomes 0.
REQ-026 flush SHALL take priority over in_valid and out_ready; out_valid in the flush cycle still reflects current state.
REQ-027 count SHALL equal the population of valid[] each cycle, registered state only (not combinational on inputs).
REQ-028 qb SHALL be ~q at all times, including during and immediately after reset.
REQ-029 in_ready depends combinationally on out_ready; no combinational path from in_valid or d to any output.

Reset
REQ-030 While reset=1: all valid = 0, all data = RESET_VAL, q = RESET_VAL, qb = ~RESET_VAL, out_valid = 0, count = 0, in_ready = 0.
REQ-031 Reset SHALL act immediately on assertion, independent of clk; mid-transfer items are discarded.
REQ-032 First transfer SHALL be possible on the first rising edge after reset deasserts.

Structure
REQ-033 Package dff_pkg SHALL hold the count-width function and a default RESET_VAL constant.
REQ-034 One sub-module dff_pipe_stage (WIDTH-bit data + valid register, async reset, load enable) SHALL be instantiated STAGES times via generate.

Verification (WIDTH=8, STAGES=3, RESET_VAL=8'h00)
REQ-035 Reset at random time, d=x -> q=8'h00, qb=8'hFF, out_valid=0, count=0, in_ready=0 while reset high.
REQ-036 Stream d=1,2,3,4 with out_ready=1 -> q=1 valid exactly 3 cycles after first transfer, then 2,3,4 on consecutive cycles; qb=~q.
REQ-037 out_ready=0, push 5 items -> first 3 accepted, count=3, in_ready=0; release out_ready -> 3 items emitted in order, no loss.
REQ-038 Full with in_valid=1 and out_ready=1 -> one accepted and one emitted per cycle, count stays 3.
REQ-039 flush with count=2 and in_valid=1 -> next cycle count=0, out_valid=0, input dropped, q unchanged.
REQ-040 Assert reset mid-stream between clk edges -> outputs reach reset values immediately; after release, d=8'hA5 emerges on q after 3 cycles.

Source files
------------

// File: rtl/dff_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dff_pkg
//  Purpose  : Shared constants and helpers for the dff_pipe pipeline.
//             - DEFAULT_RESET_VAL : bit value replicated into every data
//                                   register on reset by default.
//             - count_width()     : width of the valid-stage occupancy count.
//  Revision : 1.0 - initial release
// ============================================================================
package dff_pkg;

  localparam logic DEFAULT_RESET_VAL = 1'b0;

  // Enough bits to represent 0..stages inclusive.
  function automatic int count_width(input int stages);
    return $clog2(stages + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dff_pipe_stage.sv
`default_nettype none
// ============================================================================
//  Module   : dff_pipe_stage
//  Purpose  : One pipeline slot: a WIDTH-bit data register plus its valid
//             flag, asynchronously reset.
//  Ports    : clk       - clock, rising edge
//             reset     - asynchronous active-high reset
//             load      - capture data_in/valid_in on this edge
//             clr       - clear valid on this edge; data is left untouched
//             data_in   - data from the upstream slot (or pipeline input)
//             valid_in  - valid from the upstream slot (or input transfer)
//             data_out  - registered data
//             valid_out - registered valid
//  Revision : 1.0 - initial release
// ============================================================================
module dff_pipe_stage #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             clr,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;
  logic             valid_q;
  logic             valid_d;

  // clr wins over load so a flush neither captures new data nor keeps valids.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (clr) begin
      valid_d = 1'b0;
    end else if (load) begin
      data_d  = data_in;
      valid_d = valid_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q  <= RESET_VAL;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;

endmodule
`default_nettype wire

// File: rtl/dff_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : dff_pipe
//  Purpose  : STAGES-deep valid/ready register pipeline with bubble collapse,
//             synchronous flush and an occupancy count.
//  Ports    : clk       - clock, rising edge
//             reset     - asynchronous active-high reset
//             flush     - clear all stage valids at the next edge
//             d         - input data
//             in_valid  - d is offered for transfer
//             in_ready  - pipeline accepts d this cycle
//             q         - data of the last stage (stale when out_valid=0)
//             qb        - bitwise complement of q
//             out_valid - q holds a valid item
//             out_ready - consumer takes q this cycle
//             count     - number of valid stages
//  Revision : 1.0 - initial release
// ============================================================================
module dff_pipe
  import dff_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               STAGES    = 3,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{DEFAULT_RESET_VAL}}
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              flush,
  input  logic [WIDTH-1:0]                  d,
  input  logic                              in_valid,
  output logic                              in_ready,
  output logic [WIDTH-1:0]                  q,
  output logic [WIDTH-1:0]                  qb,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [count_width(STAGES)-1:0]    count
);

  localparam int CW = count_width(STAGES);

  logic [STAGES-1:0]            valid;
  logic [STAGES-1:0][WIDTH-1:0] data;
  logic [STAGES-1:0]            can_take;
  logic [CW-1:0]                count_w;

  // A stage can take when it, or any stage downstream of it, is empty, or
  // when the consumer drains the last stage. Written in this unrolled form
  // so no bit of can_take depends on another bit of the same vector.
  always_comb begin
    can_take = '0;
    for (int i = 0; i < STAGES; i++) begin
      can_take[i] = out_ready;
      for (int j = i; j < STAGES; j++) begin
        if (!valid[j]) can_take[i] = 1'b1;
      end
    end
  end

  // reset gating keeps in_ready low for the whole reset assertion, even
  // though the emptied pipeline would otherwise report room.
  assign in_ready = can_take[0] && !flush && !reset;

  generate
    for (genvar i = 0; i < STAGES; i++) begin : g_stage
      logic [WIDTH-1:0] stage_data_in;
      logic             stage_valid_in;

      if (i == 0) begin : g_first
        assign stage_data_in  = d;
        assign stage_valid_in = in_valid && in_ready;
      end else begin : g_rest
        assign stage_data_in  = data[i-1];
        assign stage_valid_in = valid[i-1];
      end

      dff_pipe_stage #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
      ) u_stage (
        .clk       (clk),
        .reset     (reset),
        .load      (can_take[i]),
        .clr       (flush),
        .data_in   (stage_data_in),
        .valid_in  (stage_valid_in),
        .data_out  (data[i]),
        .valid_out (valid[i])
      );
    end
  endgenerate

  // Population count of the registered valids only.
  always_comb begin
    count_w = '0;
    for (int i = 0; i < STAGES; i++) begin
      if (valid[i]) count_w = count_w + CW'(1);
    end
  end

  assign count     = count_w;
  assign q         = data[STAGES-1];
  assign qb        = ~data[STAGES-1];
  assign out_valid = valid[STAGES-1];

endmodule
`default_nettype wire

// File: tb/tb_dff_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dff_pipe
//  Purpose  : Directed self-checking bench for dff_pipe (WIDTH=8, STAGES=3).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dff_pipe;

  logic       clk;
  logic       reset;
  logic       flush;
  logic [7:0] d;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] q;
  logic [7:0] qb;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] count;

  int checks;
  int errors;

  dff_pipe #(
    .WIDTH     (8),
    .STAGES    (3),
    .RESET_VAL (8'h00)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .d         (d),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .q         (q),
    .qb        (qb),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] e;
    logic [7:0] eb;

    checks    = 0;
    errors    = 0;
    clk       = 1'b0;
    reset     = 1'b0;
    flush     = 1'b0;
    d         = 'x;
    in_valid  = 1'b0;
    out_ready = 1'b0;

    // ---- reset at an arbitrary time, d unknown ----
    #($urandom_range(2, 8));
    reset = 1'b1;
    #1;
    chk("rst_q", q, 8'h00);
    chk("rst_qb", qb, 8'hFF);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_in_ready", in_ready, 0);
    next_cycle();
    next_cycle();
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("rst_hold_in_ready", in_ready, 0);
    chk("rst_hold_out_valid", out_valid, 0);
    chk("rst_hold_q", q, 8'h00);
    chk("rst_hold_qb", qb, 8'hFF);
    reset    = 1'b0;
    in_valid = 1'b0;
    d        = 8'h00;
    next_cycle();

    // ---- stream 1,2,3,4 with out_ready=1 ----
    for (int t = 0; t < 8; t++) begin
      d         = (t < 4) ? 8'(t + 1) : 8'h00;
      in_valid  = (t < 4);
      out_ready = 1'b1;
      @(negedge clk);
      if (t < 4) chk("stream_in_ready", in_ready, 1);
      chk("stream_out_valid", out_valid, (t >= 3 && t <= 6) ? 1 : 0);
      if (t >= 3 && t <= 6) begin
        e  = 8'(t - 2);
        eb = ~e;
        chk("stream_q", q, e);
        chk("stream_qb", qb, eb);
      end
      next_cycle();
    end
    chk("stream_empty_count", count, 0);

    // ---- stalled output: offer 5 items, only 3 fit ----
    for (int t = 0; t < 5; t++) begin
      d         = 8'(8'h10 + t);
      in_valid  = 1'b1;
      out_ready = 1'b0;
      @(negedge clk);
      chk("stall_in_ready", in_ready, (t < 3) ? 1 : 0);
      chk("stall_count", count, (t < 3) ? t : 3);
      if (t >= 3) begin
        chk("stall_out_valid", out_valid, 1);
        chk("stall_q", q, 8'h10);
      end
      next_cycle();
    end
    for (int r = 0; r < 4; r++) begin
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      chk("drain_out_valid", out_valid, (r < 3) ? 1 : 0);
      chk("drain_count", count, 3 - r);
      if (r < 3) chk("drain_q", q, 8'h10 + r);
      next_cycle();
    end

    // ---- full pipeline, simultaneous accept and emit ----
    for (int t = 0; t < 3; t++) begin
      d         = 8'(8'h20 + t);
      in_valid  = 1'b1;
      out_ready = 1'b0;
      next_cycle();
    end
    for (int t = 3; t < 6; t++) begin
      d         = 8'(8'h20 + t);
      in_valid  = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      chk("full_in_ready", in_ready, 1);
      chk("full_out_valid", out_valid, 1);
      chk("full_q", q, 8'h20 + t - 3);
      chk("full_count", count, 3);
      next_cycle();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("full_after_count", count, 3);
    chk("full_after_q", q, 8'h23);
    next_cycle();
    out_ready = 1'b0;
    @(negedge clk);
    chk("pre_flush_count", count, 2);
    chk("pre_flush_q", q, 8'h24);
    next_cycle();

    // ---- flush with count=2, input and out_ready active ----
    flush     = 1'b1;
    in_valid  = 1'b1;
    d         = 8'h77;
    out_ready = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", in_ready, 0);
    chk("flush_out_valid", out_valid, 1);
    chk("flush_count", count, 2);
    next_cycle();
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    chk("post_flush_count", count, 0);
    chk("post_flush_out_valid", out_valid, 0);
    chk("post_flush_q", q, 8'h24);
    chk("post_flush_qb", qb, 8'hDB);
    next_cycle();
    @(negedge clk);
    chk("post_flush_count2", count, 0);
    next_cycle();

    // ---- asynchronous reset mid-stream ----
    for (int t = 0; t < 3; t++) begin
      d         = 8'(8'h30 + t);
      in_valid  = 1'b1;
      out_ready = 1'b1;
      next_cycle();
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("mid_q", q, 8'h30);
    chk("mid_out_valid", out_valid, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_q", q, 8'h00);
    chk("async_rst_qb", qb, 8'hFF);
    chk("async_rst_out_valid", out_valid, 0);
    chk("async_rst_count", count, 0);
    chk("async_rst_in_ready", in_ready, 0);
    @(negedge clk);
    reset     = 1'b0;
    d         = 8'hA5;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("rel_in_ready", in_ready, 1);
    chk("rel_count", count, 0);
    next_cycle();
    in_valid = 1'b0;
    d        = 8'h00;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk("rel_out_valid", out_valid, (k == 3) ? 1 : 0);
      if (k == 3) begin
        chk("rel_q", q, 8'hA5);
        chk("rel_qb", qb, 8'h5A);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
